// File: rtl/freq_gen.sv
// Programmable square-wave / burst generator: period and high time in clk_in cycles,
// continuous or for a fixed number of periods, with glitch-free retune at period boundaries.
module freq_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] high,
    input  logic [WIDTH-1:0] burst,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pulse_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_MIN = WIDTH'(2);
    localparam logic [WIDTH-1:0] SAT   = {WIDTH{1'b1}};

    // Period is never below 2 so both output levels always exist.
    function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        if (p < P_MIN) begin
            r = P_MIN;
        end else begin
            r = p;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] eff_high(input logic [WIDTH-1:0] h,
                                                  input logic [WIDTH-1:0] p_eff);
        logic [WIDTH-1:0] r;
        if (h == ZERO) begin
            r = ONE;
        end else begin
            r = h;
        end
        if (r > (p_eff - ONE)) begin
            r = p_eff - ONE;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [0:0]       state_r;
    logic [0:0]       state_s;
    logic [WIDTH-1:0] phase_r;
    logic [WIDTH-1:0] phase_s;
    logic [WIDTH-1:0] p_eff_r;
    logic [WIDTH-1:0] p_eff_s;
    logic [WIDTH-1:0] h_eff_r;
    logic [WIDTH-1:0] h_eff_s;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] n_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic             sig_r;
    logic             sig_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;

    logic             at_boundary_s;
    logic             last_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0] phase_inc_s;
    logic [WIDTH-1:0] p_new_s;

    // Boundary detection, saturating period count and burst-completion test.
    always_comb begin
        at_boundary_s = (phase_r == (p_eff_r - ONE));
        phase_inc_s   = phase_r + ONE;
        p_new_s       = eff_period(period);
        if (cnt_r == SAT) begin
            cnt_inc_s = SAT;
        end else begin
            cnt_inc_s = cnt_r + ONE;
        end
        // Compare one bit wider so a wrapped count can never match N.
        last_s = (({1'b0, cnt_r} + {1'b0, ONE}) == {1'b0, n_r});
    end

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        p_eff_s = p_eff_r;
        h_eff_s = h_eff_r;
        n_s     = n_r;
        cnt_s   = cnt_r;
        sig_s   = sig_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_s = ST_RUN;
                    p_eff_s = p_new_s;
                    h_eff_s = eff_high(high, p_new_s);
                    n_s     = burst;
                    phase_s = ZERO;
                    cnt_s   = ZERO;
                    sig_s   = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    sig_s  = 1'b0;
                    busy_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    phase_s = ZERO;
                    sig_s   = 1'b0;
                    busy_s  = 1'b0;
                end else if (at_boundary_s) begin
                    phase_s = ZERO;
                    cnt_s   = cnt_inc_s;
                    if ((n_r != ZERO) && last_s) begin
                        state_s = ST_IDLE;
                        sig_s   = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        p_eff_s = p_new_s;
                        h_eff_s = eff_high(high, p_new_s);
                        sig_s   = 1'b1;
                    end
                end else begin
                    phase_s = phase_inc_s;
                    sig_s   = (phase_inc_s < h_eff_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = ZERO;
                sig_s   = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= ZERO;
            p_eff_r <= P_MIN;
            h_eff_r <= ONE;
            n_r     <= ZERO;
            cnt_r   <= ZERO;
            sig_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            p_eff_r <= p_eff_s;
            h_eff_r <= h_eff_s;
            n_r     <= n_s;
            cnt_r   <= cnt_s;
            sig_r   <= sig_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign signal_out = sig_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pulse_cnt  = cnt_r;

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen: directed scenarios plus randomized runs, checked
// each cycle against a queue-based waveform model built from the period/high rules.
module tb_freq_gen;

    localparam int WIDTH = 16;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] burst;
    logic             signal_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] pulse_cnt;

    freq_gen #(.WIDTH(WIDTH)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .high      (high),
        .burst     (burst),
        .signal_out(signal_out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: remaining samples of the current period, plus run bookkeeping.
    bit m_run;
    bit m_q[$];
    int m_cnt;
    int m_n;
    bit e_sig;
    bit e_busy;
    bit e_done;

    int rise_cnt;
    bit prev_sig;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_period(input int p, input int h);
        int pe;
        int he;
        pe = (p < 2) ? 2 : p;
        he = (h < 1) ? 1 : h;
        if (he > pe - 1) he = pe - 1;
        for (int i = 0; i < pe; i++) m_q.push_back(i < he);
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_q.delete();
        m_cnt  = 0;
        m_n    = 0;
        e_sig  = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
    endtask

    // Expected outputs after the coming edge, from the inputs now applied.
    task automatic model_edge();
        e_done = 1'b0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1'b1;
                m_cnt = 0;
                m_n   = int'(burst);
                push_period(int'(period), int'(high));
                e_sig  = m_q.pop_front();
                e_busy = 1'b1;
            end else begin
                e_sig  = 1'b0;
                e_busy = 1'b0;
            end
        end else if (stop) begin
            m_run  = 1'b0;
            m_q.delete();
            e_sig  = 1'b0;
            e_busy = 1'b0;
        end else if (m_q.size() == 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_n != 0 && m_cnt == m_n) begin
                m_run  = 1'b0;
                e_sig  = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b1;
            end else begin
                push_period(int'(period), int'(high));
                e_sig = m_q.pop_front();
            end
        end else begin
            e_sig = m_q.pop_front();
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
        check("signal_out", 32'(signal_out), 32'(e_sig));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("pulse_cnt", 32'(pulse_cnt), 32'(m_cnt));
        if (signal_out && !prev_sig) rise_cnt++;
        prev_sig = signal_out;
    endtask

    task automatic run_start(input int p, input int h, input int n);
        period = WIDTH'(p);
        high   = WIDTH'(h);
        burst  = WIDTH'(n);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sig"}, 32'(signal_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cnt"}, 32'(pulse_cnt), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = '0;
        high   = '0;
        burst  = '0;
        rise_cnt = 0;
        prev_sig = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk_in);
        #3;
        rst_n = 1'b1;
        repeat (2) tick();

        // Burst 4/2/3: 1100 x3, done on cycle 13, count 3.
        run_start(4, 2, 3);
        repeat (11) tick();
        check("burst_busy_last", 32'(busy), 32'd1);
        tick();
        check("burst_done", 32'(done), 32'd1);
        check("burst_cnt", 32'(pulse_cnt), 32'd3);
        repeat (2) tick();
        check("burst_cnt_hold", 32'(pulse_cnt), 32'd3);

        // Clamping cases.
        run_start(0, 0, 2);
        repeat (6) tick();
        run_start(3, 7, 1);
        check("clamp_c0", 32'(signal_out), 32'd1);
        tick();
        check("clamp_c1", 32'(signal_out), 32'd1);
        tick();
        check("clamp_c2", 32'(signal_out), 32'd0);
        repeat (3) tick();

        // Continuous retune mid-period.
        run_start(5, 1, 0);
        repeat (2) tick();
        period = 16'd8;
        high   = 16'd4;
        repeat (30) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // Stop at phase 2 of period 4.
        run_start(5, 1, 0);
        repeat (3 * 5 + 2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_sig", 32'(signal_out), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_cnt", 32'(pulse_cnt), 32'd3);
        repeat (2) tick();
        run_start(3, 1, 0);
        check("restart_cnt", 32'(pulse_cnt), 32'd0);
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // start+stop in IDLE, then start during RUN.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        tick();
        run_start(6, 3, 0);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Asynchronous reset mid-burst.
        run_start(4, 2, 5);
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        @(posedge clk_in);
        #3;
        rst_n = 1'b1;
        repeat (4) tick();

        // Randomized runs with retunes, stray starts, burst changes and stops.
        for (int r = 0; r < 10; r++) begin
            run_start($urandom_range(0, 9), $urandom_range(0, 10), $urandom_range(0, 4));
            for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    period = WIDTH'($urandom_range(0, 9));
                    high   = WIDTH'($urandom_range(0, 10));
                end
                if ($urandom_range(0, 9) == 0) burst = WIDTH'($urandom_range(0, 4));
                start = ($urandom_range(0, 15) == 0);
                stop  = ($urandom_range(0, 40) == 0);
                tick();
            end
            start = 1'b0;
            stop  = 1'b1;
            tick();
            stop  = 1'b0;
            tick();
        end

        // Loopback: count rising edges in a 1000-cycle gate.
        run_start(10, 5, 0);
        rise_cnt = 0;
        repeat (1000) tick();
        check("loopback_100pm1", 32'((rise_cnt >= 99) && (rise_cnt <= 101)), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
